// File: rtl/simple_rsp_pkg.sv
// Shared types and constants for the simple_rsp responder.
package simple_rsp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACK,
    RELEASE
  } rsp_state_e;

  localparam int ACK_LAT_W = 4;
  localparam int STATS_W   = 32;

endpackage

// File: rtl/simple_rsp_if.sv
// Request/ack/data bus plus FIFO drain port. The master is the initiator/consumer side.
// Handshakes: req is a level held (with data stable) until ack is seen; ack is a one-cycle
// pulse; a word leaves the drain port on any rising edge where out_valid & out_ready.
interface simple_rsp_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              req;
  logic [DATA_W-1:0] data;
  logic              ack;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic [LVL_W-1:0]  level;

  modport master (
    output req, data, out_ready,
    input  ack, out_valid, out_data, level
  );

  modport slave (
    input  req, data, out_ready,
    output ack, out_valid, out_data, level
  );
endinterface

// File: rtl/simple_rsp_fifo.sv
// Power-of-two FIFO with a combinational head read and an occupancy count.
module simple_rsp_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [LVL_W-1:0]  level
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LVL_W'(DEPTH));
  assign level   = count;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/simple_rsp.sv
// Responder for the req/ack/data protocol: programmable ack latency, FIFO-buffered drain port.
// Define SIMPLE_RSP_STATS_EN to add the xfer_count/stall_count outputs.
module simple_rsp
  import simple_rsp_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int ACK_LATENCY = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  simple_rsp_if.slave bus,
  output rsp_state_e dbg_state
`ifdef SIMPLE_RSP_STATS_EN
  ,
  output logic [STATS_W-1:0] xfer_count,
  output logic [STATS_W-1:0] stall_count
`endif
);
  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [ACK_LAT_W-1:0] LAT_INIT = ACK_LAT_W'(ACK_LATENCY);

  rsp_state_e           state;
  rsp_state_e           state_n;
  logic [ACK_LAT_W-1:0] cnt;
  logic [ACK_LAT_W-1:0] cnt_n;
  logic                 push;
  logic                 full;
  logic                 empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Full is only checked in WAIT; pops before the write can only add space.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    push    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          cnt_n   = LAT_INIT;
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (!bus.req)        state_n = IDLE;
        else if (cnt != '0)  cnt_n   = cnt - 1'b1;
        else if (!full)      state_n = ACK;
      end
      ACK: begin
        push    = 1'b1;
        state_n = RELEASE;
      end
      RELEASE: begin
        if (!bus.req) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.ack       = (state == ACK);
  assign bus.out_valid = !empty;
  assign dbg_state     = state;

  simple_rsp_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (push),
    .wr_data(bus.data),
    .pop    (bus.out_ready),
    .rd_data(bus.out_data),
    .full   (full),
    .empty  (empty),
    .level  (bus.level)
  );

`ifdef SIMPLE_RSP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count  <= '0;
      stall_count <= '0;
    end else begin
      if (state == ACK) xfer_count <= xfer_count + 1'b1;
      if (state == WAIT && cnt == '0 && full) stall_count <= stall_count + 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_req_held_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
    (state == WAIT) |-> bus.req);
  a_data_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state == WAIT || state == ACK) |-> $stable(bus.data));
  a_level_bound: assert property (@(posedge clk) disable iff (!rst_n)
    bus.level <= LVL_W'(DEPTH));
`endif
endmodule

// File: tb/tb_simple_rsp.sv
// Bench for simple_rsp: two instances (ack latency 0 and 3) sharing one stimulus driver.
module tb_simple_rsp;
  import simple_rsp_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = $clog2(DEPTH) + 1;
  localparam int N_RAND = 400;

  typedef struct {
    logic              sel;
    logic [DATA_W-1:0] data;
    int                lat;
  } vec_t;

  // clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  simple_rsp_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) if0 ();
  simple_rsp_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) if3 ();
  rsp_state_e st0;
  rsp_state_e st3;
`ifdef SIMPLE_RSP_STATS_EN
  logic [31:0] xfer0, stall0, xfer3, stall3;
`endif

  simple_rsp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACK_LATENCY(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave), .dbg_state(st0)
`ifdef SIMPLE_RSP_STATS_EN
    , .xfer_count(xfer0), .stall_count(stall0)
`endif
  );

  simple_rsp #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ACK_LATENCY(3)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave), .dbg_state(st3)
`ifdef SIMPLE_RSP_STATS_EN
    , .xfer_count(xfer3), .stall_count(stall3)
`endif
  );

  // sel picks which instance the driver talks to; the other sees req=0, out_ready=0
  logic              sel    = 1'b0;
  logic              req_d  = 1'b0;
  logic              rdy_d  = 1'b0;
  logic [DATA_W-1:0] data_d = '0;

  assign if0.req       = req_d & ~sel;
  assign if3.req       = req_d & sel;
  assign if0.data      = data_d;
  assign if3.data      = data_d;
  assign if0.out_ready = rdy_d & ~sel;
  assign if3.out_ready = rdy_d & sel;

  wire              o_ack   = sel ? if3.ack : if0.ack;
  wire              o_valid = sel ? if3.out_valid : if0.out_valid;
  wire [DATA_W-1:0] o_data  = sel ? if3.out_data : if0.out_data;
  wire [LVL_W-1:0]  o_level = sel ? if3.level : if0.level;
  rsp_state_e       o_st;
  assign o_st = sel ? st3 : st0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  int                pass_cnt = 0;
  int                total    = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];
  bit                mon_en  = 1'b0;
  int                max_lvl = 0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (o_valid && rdy_d) got_q.push_back(o_data);
      if (int'(o_level) > max_lvl) max_lvl = int'(o_level);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    else pass_cnt++;
  endtask

  // driver tasks (all entered and left on a falling edge)
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_d = 1'b0;
    rdy_d = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ack(input int limit, output int ack_edge);
    ack_edge = -1;
    for (int i = 0; i < limit && ack_edge < 0; i++) begin
      @(negedge clk);
      if (o_ack) ack_edge = cyc;
    end
    if (ack_edge < 0) begin
      total++;
      $display("FAIL ack_timeout: no ack within %0d cycles (cycle %0d)", limit, cyc);
    end
  endtask

  // One transfer: lat = edges from the drive edge to the edge after which ack is seen.
  task automatic send(input logic [DATA_W-1:0] d, output int lat);
    int start;
    int e;
    req_d  = 1'b1;
    data_d = d;
    start  = cyc;
    wait_ack(40, e);
    lat   = (e < 0) ? -1 : e - start;
    req_d = 1'b0;
    @(negedge clk);
    chk("ack_one_cycle", o_ack, 1'b0);
    @(negedge clk);
  endtask

  // Reference: a word is acked at the first edge >= drive+2+L where the queue has room,
  // and enters the queue one edge later; pops come off the front.
  task automatic run_random(input int lat_l);
    int k;
    int ack_at  = -1;
    int push_at = -1;
    int elig    = 0;
    int gap     = 2;
    bit req_on  = 1'b0;
    logic [DATA_W-1:0] cur = '0;
    exp_q.delete();
    for (int n = 0; n < N_RAND + 200; n++) begin
      if (n >= N_RAND && !req_on && push_at < cyc) break;
      k = cyc;
      chk("rand_ack", o_ack, (ack_at == k));
      chk("rand_level", o_level, exp_q.size());
      chk("rand_valid", o_valid, (exp_q.size() != 0));
      chk("rand_data", o_data, (exp_q.size() != 0) ? exp_q[0] : '0);
      if (ack_at == k) begin
        req_d   = 1'b0;
        req_on  = 1'b0;
        push_at = k + 1;
        gap     = $urandom_range(2, 4);
      end else if (!req_on && n < N_RAND) begin
        gap--;
        if (gap == 0) begin
          cur    = DATA_W'($urandom);
          req_d  = 1'b1;
          data_d = cur;
          req_on = 1'b1;
          elig   = k + 2 + lat_l;
          ack_at = -1;
        end
      end
      rdy_d = 1'($urandom_range(0, 1));
      if (req_on && ack_at < 0 && k + 1 >= elig && exp_q.size() < DEPTH) ack_at = k + 1;
      if (rdy_d && exp_q.size() != 0) void'(exp_q.pop_front());
      if (push_at == k + 1) exp_q.push_back(cur);
      @(negedge clk);
    end
    req_d = 1'b0;
    rdy_d = 1'b0;
  endtask

  initial begin
    vec_t vecs[4];
    int   lat;
    int   e;
    int   e0;

    vecs[0] = '{sel: 1'b0, data: 8'hA5, lat: 2};
    vecs[1] = '{sel: 1'b1, data: 8'h3C, lat: 5};
    vecs[2] = '{sel: 1'b0, data: 8'h5A, lat: 2};
    vecs[3] = '{sel: 1'b1, data: 8'hC3, lat: 5};

    // reset values on both instances
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      chk("rst_ack", o_ack, 1'b0);
      chk("rst_valid", o_valid, 1'b0);
      chk("rst_data", o_data, '0);
      chk("rst_level", o_level, '0);
      chk("rst_state", o_st, IDLE);
    end
    sel   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    // table: single transfer into an empty FIFO, then pop it
    foreach (vecs[i]) begin
      sel = vecs[i].sel;
      @(negedge clk);
      send(vecs[i].data, lat);
      chk("tbl_latency", lat, vecs[i].lat);
      chk("tbl_valid", o_valid, 1'b1);
      chk("tbl_data", o_data, vecs[i].data);
      chk("tbl_level", o_level, 1);
      rdy_d = 1'b1;
      @(negedge clk);
      rdy_d = 1'b0;
      chk("tbl_pop_level", o_level, 0);
      chk("tbl_pop_valid", o_valid, 1'b0);
      chk("tbl_pop_data", o_data, '0);
    end

    // latency 3, req held two cycles past ack
    sel = 1'b1;
    @(negedge clk);
    req_d  = 1'b1;
    data_d = 8'h3C;
    e0     = cyc;
    wait_ack(40, e);
    chk("hold_latency", e - e0, 5);
    repeat (2) begin
      @(negedge clk);
      chk("hold_no_reack", o_ack, 1'b0);
    end
    req_d = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hold_no_reack_after", o_ack, 1'b0);
    end
    chk("hold_state_idle", o_st, IDLE);
    chk("hold_level", o_level, 1);
    chk("hold_data", o_data, 8'h3C);
    rdy_d = 1'b1;
    @(negedge clk);
    rdy_d = 1'b0;

    // backpressure: fill four words, fifth stalls until one pop
    sel = 1'b0;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      send(DATA_W'(i), lat);
      chk("fill_latency", lat, 2);
    end
    chk("fill_level", o_level, 4);
    chk("fill_head", o_data, 8'h01);
    req_d  = 1'b1;
    data_d = 8'h05;
    repeat (4) begin
      @(negedge clk);
      chk("stall_no_ack", o_ack, 1'b0);
      chk("stall_state", o_st, WAIT);
    end
    rdy_d = 1'b1;
    e0    = cyc;
    @(negedge clk);
    rdy_d = 1'b0;
    chk("stall_pop_level", o_level, 3);
    chk("stall_pop_head", o_data, 8'h02);
    wait_ack(20, e);
    chk("unstall_latency", e - e0, 2);
    req_d = 1'b0;
    repeat (2) @(negedge clk);
    chk("unstall_level", o_level, 4);
    chk("unstall_head", o_data, 8'h02);
`ifdef SIMPLE_RSP_STATS_EN
    // four WAIT edges saw a full FIFO before the pop freed a slot
    chk("stats_xfer", xfer0, 5);
    chk("stats_stall", stall0, 4);
`endif
    rdy_d = 1'b1;
    for (int v = 2; v <= 5; v++) begin
      chk("drain_order", o_data, DATA_W'(v));
      @(negedge clk);
    end
    rdy_d = 1'b0;
    chk("drain_empty", o_valid, 1'b0);
    chk("drain_level", o_level, 0);

    // ten back-to-back transfers with the consumer always ready (pointers wrap)
    got_q.delete();
    max_lvl = 0;
    rdy_d   = 1'b1;
    mon_en  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(DATA_W'(i), lat);
      chk("wrap_latency", lat, 2);
    end
    mon_en = 1'b0;
    rdy_d  = 1'b0;
    chk("wrap_count", got_q.size(), 10);
    for (int i = 0; i < got_q.size() && i < 10; i++) chk("wrap_order", got_q[i], DATA_W'(i));
    chk("wrap_max_level", (max_lvl <= 2), 1'b1);

    // asynchronous reset while a request sits in WAIT with two words buffered
    send(8'h11, lat);
    send(8'h22, lat);
    chk("prerst_level", o_level, 2);
    req_d  = 1'b1;
    data_d = 8'h33;
    @(negedge clk);
    chk("prerst_state", o_st, WAIT);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ack", o_ack, 1'b0);
    chk("async_rst_valid", o_valid, 1'b0);
    chk("async_rst_level", o_level, 0);
    chk("async_rst_data", o_data, '0);
    chk("async_rst_state", o_st, IDLE);
    req_d = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(8'h44, lat);
    chk("postrst_latency", lat, 2);
    chk("postrst_level", o_level, 1);
    chk("postrst_data", o_data, 8'h44);

    // randomized traffic against the reference, both latencies
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      run_random(s == 0 ? 0 : 3);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end
endmodule
